// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - shared ALU control codes, FSM state type and helpers for muldiv_ctrl
package muldiv_ctrl_pkg;

    localparam logic [4:0] ALU_MULT  = 5'd16;
    localparam logic [4:0] ALU_MULTU = 5'd17;
    localparam logic [4:0] ALU_DIV   = 5'd18;
    localparam logic [4:0] ALU_DIVU  = 5'd19;
    localparam logic [4:0] ALU_MTHI  = 5'd20;
    localparam logic [4:0] ALU_MTLO  = 5'd21;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Magnitude of v when it is to be read as a signed value, otherwise v unchanged.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - EX-stage request and HI/LO result bundle for muldiv_ctrl
interface muldiv_ctrl_if;

    logic        start_i;
    logic [4:0]  alucontrol_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        stall_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        done_o;

    modport master (
        output start_i, alucontrol_i, a_i, b_i, flush_i,
        input  stall_o, hi_o, lo_o, done_o
    );

    modport slave (
        input  start_i, alucontrol_i, a_i, b_i, flush_i,
        output stall_o, hi_o, lo_o, done_o
    );

endinterface

// File: rtl/muldiv_ctrl_div_radix2.sv
// rtl/muldiv_ctrl_div_radix2.sv - restoring unsigned radix-2 divider, one quotient bit per step
module div_radix2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient_next,
    output logic [31:0] remainder_next
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        fits;

    // Partial remainder is always below the divisor, so a borrow in bit 32 means "does not fit".
    assign shifted        = {rem_q, quo_q[31]};
    assign diff           = shifted - {1'b0, dvs_q};
    assign fits           = ~diff[32];
    assign remainder_next = fits ? diff[31:0] : shifted[31:0];
    assign quotient_next  = {quo_q[30:0], fits};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            rem_q <= remainder_next;
            quo_q <= quotient_next;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multi-cycle HI/LO multiply/divide controller with pipeline stall
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_ctrl_if.slave bus
);

    localparam logic [5:0] MUL_N = 6'(MUL_CYCLES);
    localparam logic [5:0] DIV_N = 6'(DIV_CYCLES);

    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        op_signed;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    logic        in_mul;
    logic        in_div;
    logic        in_signed;
    logic        accept;
    logic        div_load;
    logic        div_step;
    logic        last;
    logic [31:0] q_next;
    logic [31:0] r_next;
    logic [31:0] q_res;
    logic [31:0] r_res;
    logic [63:0] ma;
    logic [63:0] mb;
    logic [63:0] prod;

    assign in_mul    = (bus.alucontrol_i == ALU_MULT) || (bus.alucontrol_i == ALU_MULTU);
    assign in_div    = (bus.alucontrol_i == ALU_DIV)  || (bus.alucontrol_i == ALU_DIVU);
    assign in_signed = (bus.alucontrol_i == ALU_MULT) || (bus.alucontrol_i == ALU_DIV);
    assign accept    = (state == ST_IDLE) && bus.start_i && !bus.flush_i && (in_mul || in_div);
    assign div_load  = accept && in_div;
    assign div_step  = (state == ST_DIV) && !bus.flush_i;
    assign last      = (cnt == 6'd1);

    assign bus.stall_o = accept || (((state == ST_MUL) || (state == ST_DIV)) && !bus.flush_i);
    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;
    assign bus.done_o  = done_q;

    // Sign- or zero-extend to 64 bits so one multiplier serves both MULT and MULTU.
    assign ma   = {{32{op_signed & a_q[31]}}, a_q};
    assign mb   = {{32{op_signed & b_q[31]}}, b_q};
    assign prod = ma * mb;

    div_radix2 u_div (
        .clk            (clk),
        .rst            (rst),
        .load           (div_load),
        .step           (div_step),
        .dividend       (magnitude(bus.a_i, in_signed)),
        .divisor        (magnitude(bus.b_i, in_signed)),
        .quotient_next  (q_next),
        .remainder_next (r_next)
    );

    // Quotient negative when operand signs differ; remainder follows the dividend.
    assign q_res = (op_signed && (a_q[31] ^ b_q[31])) ? (~q_next + 32'd1) : q_next;
    assign r_res = (op_signed && a_q[31]) ? (~r_next + 32'd1) : r_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_signed <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush_i) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            a_q       <= bus.a_i;
                            b_q       <= bus.b_i;
                            op_signed <= in_signed;
                            if (in_mul) begin
                                cnt   <= MUL_N;
                                state <= ST_MUL;
                            end else if (bus.b_i == '0) begin
                                state  <= ST_DONE;
                                done_q <= 1'b1;
                            end else begin
                                cnt   <= DIV_N;
                                state <= ST_DIV;
                            end
                        end else if (bus.start_i && (bus.alucontrol_i == ALU_MTHI)) begin
                            hi_q <= bus.a_i;
                        end else if (bus.start_i && (bus.alucontrol_i == ALU_MTLO)) begin
                            lo_q <= bus.a_i;
                        end
                    end
                    ST_MUL: begin
                        if (last) begin
                            hi_q   <= prod[63:32];
                            lo_q   <= prod[31:0];
                            cnt    <= '0;
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            cnt <= cnt - 6'd1;
                        end
                    end
                    ST_DIV: begin
                        if (last) begin
                            hi_q   <= r_res;
                            lo_q   <= q_res;
                            cnt    <= '0;
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            cnt <= cnt - 6'd1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl against an arithmetic HI/LO model
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_ctrl_if bus ();

    muldiv_ctrl #(.MUL_CYCLES(2), .DIV_CYCLES(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          errors = 0;
    int          checks = 0;
    bit          chk_en = 1'b0;
    logic        exp_stall = 1'b0;
    logic        exp_done = 1'b0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    int          stall_cnt = 0;
    int          done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // HI/LO after an op, from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint          sa, sb, sq, sr, sp;
        longint unsigned up;
        logic [31:0]     uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            ALU_MULT:  begin sp = sa * sb; return sp; end
            ALU_MULTU: begin up = 64'(a) * 64'(b); return up; end
            ALU_DIV: begin
                if (b == 0) return {hi, lo};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            ALU_DIVU: begin
                if (b == 0) return {hi, lo};
                uq = a / b;
                ur = a % b;
                return {ur, uq};
            end
            default: return {hi, lo};
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall_o", bus.stall_o, exp_stall);
            check("done_o", bus.done_o, exp_done);
            check("hi_o", bus.hi_o, exp_hi);
            check("lo_o", bus.lo_o, exp_lo);
            if (bus.stall_o) stall_cnt++;
            if (bus.done_o) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input bit flush_done);
        logic [63:0] r;
        int          n;
        bit          flushed;
        r = model(op, a, b, exp_hi, exp_lo);
        n = (op == ALU_MULT || op == ALU_MULTU) ? 2 : ((b == 0) ? 0 : 32);
        flushed = 1'b0;
        stall_cnt = 0;
        done_cnt = 0;
        bus.start_i = 1'b1;
        bus.alucontrol_i = op;
        bus.a_i = a;
        bus.b_i = b;
        exp_stall = 1'b1;
        exp_done = 1'b0;
        step();
        bus.start_i = 1'b0;
        for (int i = 1; i <= n; i++) begin
            if (i == flush_at) begin
                bus.flush_i = 1'b1;
                exp_stall = 1'b0;
            end
            step();
            if (i == flush_at) begin
                bus.flush_i = 1'b0;
                flushed = 1'b1;
                break;
            end
        end
        exp_stall = 1'b0;
        if (!flushed) begin
            exp_done = 1'b1;
            exp_hi = r[63:32];
            exp_lo = r[31:0];
            bus.start_i = 1'b1;
            bus.alucontrol_i = ALU_MULT;
            bus.a_i = 32'd3;
            bus.b_i = 32'd3;
            bus.flush_i = flush_done;
            step();
            bus.start_i = 1'b0;
            bus.flush_i = 1'b0;
            exp_done = 1'b0;
        end
        step();
        step();
        check("stall_cycles", stall_cnt, flushed ? flush_at : n + 1);
        check("done_pulses", done_cnt, flushed ? 0 : 1);
    endtask

    task automatic move_to(input logic [4:0] op, input logic [31:0] a, input bit flush);
        stall_cnt = 0;
        done_cnt = 0;
        bus.start_i = 1'b1;
        bus.alucontrol_i = op;
        bus.a_i = a;
        bus.flush_i = flush;
        exp_stall = 1'b0;
        step();
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        if (!flush && op == ALU_MTHI) exp_hi = a;
        if (!flush && op == ALU_MTLO) exp_lo = a;
        step();
        check("move_no_stall", stall_cnt, 0);
        check("move_no_done", done_cnt, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.alucontrol_i = '0;
        bus.a_i = '0;
        bus.b_i = '0;
        bus.flush_i = 1'b0;
        chk_en = 1'b1;
        step();
        step();
        rst = 1'b0;

        run_op(ALU_MULT, 32'hFFFFFFFF, 32'd2, -1, 1'b0);
        check("mult_hi_lit", bus.hi_o, 32'hFFFFFFFF);
        check("mult_lo_lit", bus.lo_o, 32'hFFFFFFFE);
        run_op(ALU_MULTU, 32'hFFFFFFFF, 32'd2, -1, 1'b0);
        check("multu_hi_lit", bus.hi_o, 32'h00000001);
        check("multu_lo_lit", bus.lo_o, 32'hFFFFFFFE);
        run_op(ALU_DIV, 32'hFFFFFFF9, 32'd2, -1, 1'b0);
        check("div_lo_lit", bus.lo_o, 32'hFFFFFFFD);
        check("div_hi_lit", bus.hi_o, 32'hFFFFFFFF);
        run_op(ALU_DIVU, 32'd100, 32'd7, -1, 1'b0);
        check("divu_lo_lit", bus.lo_o, 32'd14);
        check("divu_hi_lit", bus.hi_o, 32'd2);
        run_op(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0);
        check("div_ovf_lo_lit", bus.lo_o, 32'h80000000);
        check("div_ovf_hi_lit", bus.hi_o, 32'h00000000);
        run_op(ALU_DIV, 32'hFFFFFF9C, 32'hFFFFFFF9, -1, 1'b0);
        run_op(ALU_DIV, 32'd100, 32'hFFFFFFF9, -1, 1'b0);
        run_op(ALU_DIVU, 32'hFFFFFFFF, 32'd1, -1, 1'b0);
        run_op(ALU_MULT, 32'h80000000, 32'h80000000, -1, 1'b0);
        run_op(ALU_MULTU, 32'h12345678, 32'h9ABCDEF0, -1, 1'b0);

        move_to(ALU_MTHI, 32'h11, 1'b0);
        move_to(ALU_MTLO, 32'h22, 1'b0);
        run_op(ALU_DIV, 32'd5, 32'd0, -1, 1'b0);
        check("div0_hi_lit", bus.hi_o, 32'h11);
        check("div0_lo_lit", bus.lo_o, 32'h22);
        run_op(ALU_DIVU, 32'd9, 32'd0, -1, 1'b0);

        run_op(ALU_DIVU, 32'd1000, 32'd3, 10, 1'b0);
        move_to(ALU_MTHI, 32'hABCD, 1'b0);
        check("mthi_lit", bus.hi_o, 32'h0000ABCD);

        move_to(ALU_MULT, 32'd5, 1'b1);
        move_to(ALU_MTLO, 32'hDEAD, 1'b1);
        run_op(ALU_MULT, 32'd7, 32'd6, 2, 1'b0);
        run_op(ALU_MULTU, 32'd7, 32'd6, -1, 1'b1);

        stall_cnt = 0;
        done_cnt = 0;
        bus.start_i = 1'b1;
        bus.alucontrol_i = ALU_DIV;
        bus.a_i = 32'd50;
        bus.b_i = 32'd3;
        exp_stall = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int i = 1; i < 20; i++) step();
        #2;
        rst = 1'b1;
        exp_stall = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        #1;
        check("rst_stall_now", bus.stall_o, 1'b0);
        check("rst_hi_now", bus.hi_o, 32'h0);
        check("rst_lo_now", bus.lo_o, 32'h0);
        step();
        step();
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) step();
        check("rst_no_done", done_cnt, 0);

        run_op(ALU_MULT, 32'hFFFFFFFD, 32'd4, -1, 1'b0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter MUL_CYCLES, default 2, compute cycles for MULT/MULTU (1..8).
REQ-002 Parameter DIV_CYCLES, fixed 32, compute cycles for DIV/DIVU (one per quotient bit).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start_i  in  1  EX-stage instruction valid and is a HI/LO-class op.
REQ-006 alucontrol_i  in  5  ALU control code; ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_MTHI and ALU_MTLO act; all other codes are ignored.
REQ-007 a_i  in  32  rs operand (dividend/multiplicand; MTHI/MTLO source).
REQ-008 b_i  in  32  rt operand (divisor/multiplier).
REQ-009 flush_i  in  1  exception/cancel; aborts any in-flight operation.
REQ-010 stall_o  out  1  holds pipeline IF..EX while high.
REQ-011 hi_o, lo_o  out  32 each  architectural HI/LO registers.
REQ-012 done_o  out  1  one-cycle pulse in the cycle after HI/LO are updated by mul/div.

Function
REQ-013 FSM states: IDLE, MUL, DIV, DONE.
REQ-014 In IDLE, start_i with MULT/MULTU or DIV/DIVU (accept cycle T) latches a_i, b_i and the op, sets stall_o=1 combinationally in T, and goes to MUL or DIV.
REQ-015 MUL and DIV last N=MUL_CYCLES or N=DIV_CYCLES cycles (T+1..T+N); a 6-bit counter counts down; stall_o=1 throughout.
REQ-016 At the edge ending cycle T+N, HI/LO are written and the FSM enters DONE; in DONE stall_o=0, done_o=1, start_i is ignored, and the next state is IDLE.
REQ-017 Total stall is N+1 cycles: 3 for MULT at default MUL_CYCLES, 33 for DIV.
REQ-018 MULT produces a signed 64-bit product and MULTU an unsigned one; HI = product[63:32], LO = product[31:0].
REQ-019 DIVU: LO = unsigned quotient, HI = unsigned remainder.
REQ-020 DIV divides magnitudes and then fixes signs; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
REQ-022 Divisor zero (DIV or DIVU): the FSM goes directly T -> DONE, stall_o is high only in T, HI/LO are unchanged, and done_o pulses.
REQ-023 MTHI/MTLO in IDLE with start_i: the HI/LO register is written with a_i at the end of that cycle; there is no stall and no done_o.
REQ-024 flush_i high in any state forces stall_o=0 that cycle and returns the FSM to IDLE at the next edge.
REQ-025 flush_i blocks any HI/LO write scheduled for that edge, including a final MUL/DIV write or MTHI/MTLO.
REQ-026 flush_i high in DONE has no effect on HI/LO, which were already written.
REQ-027 flush_i together with start_i in IDLE: no accept.
REQ-028 hi_o and lo_o are driven directly from registers; MFHI/MFLO read them with no controller action.

Reset
REQ-029 rst asserted: state=IDLE, counter=0, hi_o=0, lo_o=0, stall_o=0, done_o=0, latched operands=0, asynchronously.
REQ-030 rst mid-operation discards the operation with no HI/LO write.
REQ-031 After rst deasserts, the first edge may accept start_i.

Structure
REQ-032 ALU control codes come only from the shared define_alu_control.vh; FSM encodings are local parameters in this module.
REQ-033 A sub-module div_radix2 performs 32-cycle restoring unsigned division on magnitudes under load/step control from this FSM.
REQ-034 Sign handling and the multiplier stay in muldiv_ctrl.

Verification
REQ-035 MULT a=0xFFFFFFFF, b=2 -> stall_o high 3 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE; done_o pulses once.
REQ-036 MULTU a=0xFFFFFFFF, b=2 -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-037 DIV a=-7, b=2 -> stall_o high 33 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-038 DIVU a=100, b=7 -> LO=14, HI=2.
REQ-039 DIV a=5, b=0 with prior HI=0x11, LO=0x22 -> stall_o high 1 cycle; HI/LO stay 0x11/0x22; done_o pulses.
REQ-040 DIVU started, flush_i in compute cycle 10 -> stall_o=0 that cycle, IDLE next; HI/LO unchanged; a following MTHI a=0xABCD gives HI=0xABCD with no stall.
REQ-041 rst asserted in DIV cycle 20 -> immediately stall_o=0, HI=LO=0; no done_o afterwards.
